// File: rtl/fa_factorial_ctrl.sv
// -----------------------------------------------------------------------------
// fa_factorial_ctrl
//
// Sequencing controller that computes n! by stepping a shared 32-bit
// combinational ALU through a multiply / decrement / compare loop. The
// controller owns the ALU operand and opcode inputs. It captures the ALU
// result into its accumulator (acc) and counter (cnt) registers.
//
// Ports:
//   clk          in   1   system clock, rising-edge active
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   run request, accepted only in IDLE
//   n_in         in   5   operand n (0..31), latched when start is accepted
//   busy         out  1   high whenever the FSM is outside IDLE
//   done         out  1   one-cycle pulse while in DONE
//   result       out  32  n! mod 2^32, held until the next accepted start
//   overflow     out  1   latched (n_in > 12): true n! does not fit 32 bits
//   alu_a        out  32  ALU operand a
//   alu_b        out  32  ALU operand b
//   alu_op       out  3   ALU opcode (000 add, 001 sub, 010 mul)
//   alu_result   in   32  ALU combinational result
//   alu_is_zero  in   1   ALU equality flag (a == b)
//
// Latency from the accepting IDLE cycle to done is 3*max(n-1,0)+1 cycles.
// -----------------------------------------------------------------------------
module fa_factorial_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  n_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_is_zero
);

    // Only these three opcodes are ever issued.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;

    // Largest n whose factorial still fits in 32 bits.
    localparam logic [4:0] N_MAX_EXACT = 5'd12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DEC   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] acc_q,      acc_d;
    logic [31:0] cnt_q,      cnt_d;
    logic [31:0] result_q,   result_d;
    logic        overflow_q, overflow_d;

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= 32'd0;
            cnt_q      <= 32'd0;
            result_q   <= 32'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state, register updates and ALU drive for each state.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        alu_op     = OP_ADD;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d      = {27'd0, n_in};
                    acc_d      = 32'd1;
                    overflow_d = (n_in > N_MAX_EXACT);
                    // 0! and 1! need no loop at all.
                    if (n_in <= 5'd1) begin
                        result_d = 32'd1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MUL: begin
                alu_a   = acc_q;
                alu_b   = cnt_q;
                alu_op  = OP_MUL;
                acc_d   = alu_result;
                state_d = ST_DEC;
            end

            ST_DEC: begin
                alu_a   = cnt_q;
                alu_b   = 32'd1;
                alu_op  = OP_SUB;
                cnt_d   = alu_result;
                state_d = ST_CHECK;
            end

            ST_CHECK: begin
                // The add result is not used; only the a==b flag matters here.
                alu_a  = cnt_q;
                alu_b  = 32'd1;
                alu_op = OP_ADD;
                if (alu_is_zero) begin
                    result_d = acc_q;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_MUL;
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule
